// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Writer side of the CPU program memory. A 2^ADDR_WIDTH x DATA_WIDTH RAM is
//   cleared after reset, filled from the board switches one push-button press
//   at a time while the CPU is held in reset, and read combinationally by the
//   CPU fetch path at all times.
//
// Ports
//   clk          in   system clock (divided CPU clock)
//   reset        in   asynchronous, active-high reset
//   loadMode     in   1 = program entry, 0 = run
//   writeStrobe  in   debounced push-button, asynchronous to clk
//   dataIn       in   opcode to store
//   readAddr     in   CPU program counter
//   readData     out  opcode at readAddr (combinational)
//   cpuHold      out  registered; 1 keeps the CPU in reset
//   wrAddr       out  registered next write address / words loaded
//   memFull      out  registered; 1 once the last address has been written
//   loaderState  out  registered state: 00 CLEAR, 01 LOAD, 10 RUN
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadMode,
  input  logic                  writeStrobe,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  cpuHold,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic                  memFull,
  output logic [1:0]            loaderState
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic                    mem_full_r;
  logic                    cpu_hold_r;
  logic                    strobe_s1_r;
  logic                    strobe_s2_r;
  logic                    strobe_s3_r;

  logic                    write_pulse_s;
  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_wa_s;
  logic [DATA_WIDTH-1:0]   mem_wd_s;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // s1/s2 synchronise the button; s3 lets us fire once on the rising edge only.
  assign write_pulse_s = strobe_s2_r & ~strobe_s3_r;

  // Memory write port select: zero-fill while clearing, switch data while loading.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = wr_addr_r;
    mem_wd_s = DATA_ZERO;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        mem_wd_s = DATA_ZERO;
      end
      ST_LOAD: begin
        if (write_pulse_s && !mem_full_r) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
        mem_wd_s = dataIn;
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Synchronous memory write; contents are deliberately not reset (CLEAR does it).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_wa_s] <= mem_wd_s;
    end
  end

  // Combinational fetch port for the CPU.
  assign readData = mem[readAddr];

  // Loader FSM, strobe synchroniser and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_CLEAR;
      wr_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_full_r  <= 1'b0;
      cpu_hold_r  <= 1'b1;
      strobe_s1_r <= 1'b0;
      strobe_s2_r <= 1'b0;
      strobe_s3_r <= 1'b0;
    end else begin
      strobe_s1_r <= writeStrobe;
      strobe_s2_r <= strobe_s1_r;
      strobe_s3_r <= strobe_s2_r;
      case (state_r)
        ST_CLEAR: begin
          // Walks every address once; wraps to 0 on the last one.
          wr_addr_r <= wr_addr_r + ADDR_ONE;
          if (wr_addr_r == LAST_ADDR) begin
            if (loadMode) begin
              state_r    <= ST_LOAD;
              cpu_hold_r <= 1'b1;
            end else begin
              state_r    <= ST_RUN;
              cpu_hold_r <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (loadMode) begin
            state_r    <= ST_LOAD;
            cpu_hold_r <= 1'b1;
            wr_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_full_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Saturate at the last address instead of wrapping over the program.
          if (write_pulse_s && !mem_full_r) begin
            if (wr_addr_r == LAST_ADDR) begin
              mem_full_r <= 1'b1;
            end else begin
              wr_addr_r <= wr_addr_r + ADDR_ONE;
            end
          end
          // A pulse coinciding with loadMode falling is still written above.
          if (!loadMode) begin
            state_r    <= ST_RUN;
            cpu_hold_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_CLEAR;
          cpu_hold_r <= 1'b1;
          wr_addr_r  <= {ADDR_WIDTH{1'b0}};
          mem_full_r <= 1'b0;
        end
      endcase
    end
  end

  assign cpuHold     = cpu_hold_r;
  assign wrAddr      = wr_addr_r;
  assign memFull     = mem_full_r;
  assign loaderState = state_r;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Self-checking bench for program_loader. Written words are recorded in a
//   scoreboard queue as presses are driven and compared against readData when
//   the memory is read back.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       loadMode;
  logic       writeStrobe;
  logic [3:0] dataIn;
  logic [7:0] readAddr;
  logic [3:0] readData;
  logic       cpuHold;
  logic [7:0] wrAddr;
  logic       memFull;
  logic [1:0] loaderState;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Bench model of the write pointer
  logic [7:0] exp_addr;
  logic       exp_full;

  program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .loadMode    (loadMode),
    .writeStrobe (writeStrobe),
    .dataIn      (dataIn),
    .readAddr    (readAddr),
    .readData    (readData),
    .cpuHold     (cpuHold),
    .wrAddr      (wrAddr),
    .memFull     (memFull),
    .loaderState (loaderState)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One button press: high 3 cycles, low 3 cycles; model updates if it should write.
  task automatic press(input logic [3:0] d, input bit in_load);
    @(negedge clk);
    dataIn = d;
    writeStrobe = 1'b1;
    if (in_load && !exp_full) begin
      sb.push_back('{addr: exp_addr, data: d});
      if (exp_addr == 8'hFF) exp_full = 1'b1;
      else exp_addr = exp_addr + 8'd1;
    end
    repeat (3) @(negedge clk);
    writeStrobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic enter_load();
    @(negedge clk);
    loadMode = 1'b1;
    @(posedge clk);
    #1;
    exp_addr = 8'h00;
    exp_full = 1'b0;
  endtask

  task automatic enter_run();
    @(negedge clk);
    loadMode = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (loaderState !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", loaderState); end
    n_checks++; if (cpuHold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b want 1", cpuHold); end
    n_checks++; if (wrAddr !== 8'h00) begin n_fail++; $display("FAIL reset_wraddr: got %h want 00", wrAddr); end
    n_checks++; if (memFull !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", memFull); end
  endtask

  task automatic test_clear_to_run();
    @(negedge clk);
    reset = 1'b0;
    loadMode = 1'b0;
    repeat (255) @(posedge clk);
    #1;
    n_checks++; if (loaderState !== 2'b00) begin n_fail++; $display("FAIL clear_255_state: got %b want 00", loaderState); end
    n_checks++; if (cpuHold !== 1'b1) begin n_fail++; $display("FAIL clear_255_hold: got %b want 1", cpuHold); end
    n_checks++; if (wrAddr !== 8'hFF) begin n_fail++; $display("FAIL clear_255_wraddr: got %h want ff", wrAddr); end
    @(posedge clk);
    #1;
    n_checks++; if (loaderState !== 2'b10) begin n_fail++; $display("FAIL clear_256_state: got %b want 10", loaderState); end
    n_checks++; if (cpuHold !== 1'b0) begin n_fail++; $display("FAIL clear_256_hold: got %b want 0", cpuHold); end
    n_checks++; if (wrAddr !== 8'h00) begin n_fail++; $display("FAIL clear_256_wraddr: got %h want 00", wrAddr); end
    exp_addr = 8'h00;
    exp_full = 1'b0;
    sb.push_back('{addr: 8'h00, data: 4'h0});
    sb.push_back('{addr: 8'h7F, data: 4'h0});
    sb.push_back('{addr: 8'hFF, data: 4'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); readAddr = e.addr; #1;
      n_checks++; if (readData !== e.data) begin n_fail++; $display("FAIL clear_read[%h]: got %h want %h", e.addr, readData, e.data); end
    end
  endtask

  task automatic test_load_basic();
    enter_load();
    n_checks++; if (loaderState !== 2'b01) begin n_fail++; $display("FAIL load_state: got %b want 01", loaderState); end
    n_checks++; if (cpuHold !== 1'b1) begin n_fail++; $display("FAIL load_hold: got %b want 1", cpuHold); end
    press(4'h3, 1'b1);
    press(4'hA, 1'b1);
    press(4'h5, 1'b1);
    enter_run();
    n_checks++; if (wrAddr !== 8'h03) begin n_fail++; $display("FAIL load_wraddr: got %h want 03", wrAddr); end
    n_checks++; if (cpuHold !== 1'b0) begin n_fail++; $display("FAIL load_run_hold: got %b want 0", cpuHold); end
    n_checks++; if (loaderState !== 2'b10) begin n_fail++; $display("FAIL load_run_state: got %b want 10", loaderState); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); readAddr = e.addr; #1;
      n_checks++; if (readData !== e.data) begin n_fail++; $display("FAIL load_read[%h]: got %h want %h", e.addr, readData, e.data); end
    end
  endtask

  task automatic test_hold_strobe();
    enter_load();
    @(negedge clk);
    dataIn = 4'h9;
    writeStrobe = 1'b1;
    sb.push_back('{addr: 8'h00, data: 4'h9});
    @(posedge clk); #1;
    n_checks++; if (wrAddr !== 8'h00) begin n_fail++; $display("FAIL hold_edge1: got %h want 00", wrAddr); end
    @(posedge clk); #1;
    n_checks++; if (wrAddr !== 8'h00) begin n_fail++; $display("FAIL hold_edge2: got %h want 00", wrAddr); end
    @(posedge clk); #1;
    n_checks++; if (wrAddr !== 8'h01) begin n_fail++; $display("FAIL hold_edge3: got %h want 01", wrAddr); end
    repeat (17) @(posedge clk);
    #1;
    n_checks++; if (wrAddr !== 8'h01) begin n_fail++; $display("FAIL hold_20cyc: got %h want 01", wrAddr); end
    @(negedge clk);
    writeStrobe = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (wrAddr !== 8'h01) begin n_fail++; $display("FAIL hold_release: got %h want 01", wrAddr); end
    exp_addr = 8'h01;
    while (sb.size() > 0) begin
      e = sb.pop_front(); readAddr = e.addr; #1;
      n_checks++; if (readData !== e.data) begin n_fail++; $display("FAIL hold_read[%h]: got %h want %h", e.addr, readData, e.data); end
    end
  endtask

  task automatic test_fill();
    enter_run();
    enter_load();
    for (int i = 0; i < 257; i++) begin
      press(4'(i), 1'b1);
      if (i == 254) begin
        n_checks++; if (memFull !== 1'b0) begin n_fail++; $display("FAIL fill_255_full: got %b want 0", memFull); end
        n_checks++; if (wrAddr !== 8'hFF) begin n_fail++; $display("FAIL fill_255_wraddr: got %h want ff", wrAddr); end
      end
      if (i == 255) begin
        n_checks++; if (memFull !== 1'b1) begin n_fail++; $display("FAIL fill_256_full: got %b want 1", memFull); end
        n_checks++; if (wrAddr !== 8'hFF) begin n_fail++; $display("FAIL fill_256_wraddr: got %h want ff", wrAddr); end
      end
    end
    n_checks++; if (memFull !== 1'b1) begin n_fail++; $display("FAIL fill_257_full: got %b want 1", memFull); end
    n_checks++; if (wrAddr !== 8'hFF) begin n_fail++; $display("FAIL fill_257_wraddr: got %h want ff", wrAddr); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); readAddr = e.addr; #1;
      n_checks++; if (readData !== e.data) begin n_fail++; $display("FAIL fill_read[%h]: got %h want %h", e.addr, readData, e.data); end
    end
  endtask

  task automatic test_coincident();
    enter_run();
    enter_load();
    n_checks++; if (memFull !== 1'b0) begin n_fail++; $display("FAIL coin_full_cleared: got %b want 0", memFull); end
    @(negedge clk);
    dataIn = 4'hC;
    writeStrobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    loadMode = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (loaderState !== 2'b10) begin n_fail++; $display("FAIL coin_state: got %b want 10", loaderState); end
    n_checks++; if (cpuHold !== 1'b0) begin n_fail++; $display("FAIL coin_hold: got %b want 0", cpuHold); end
    n_checks++; if (wrAddr !== 8'h01) begin n_fail++; $display("FAIL coin_wraddr: got %h want 01", wrAddr); end
    sb.push_back('{addr: 8'h00, data: 4'hC});
    exp_addr = 8'h01;
    @(negedge clk);
    writeStrobe = 1'b0;
    repeat (3) @(negedge clk);
    // A press in RUN must not write; address 1 still holds the fill value 1.
    press(4'h7, 1'b0);
    n_checks++; if (wrAddr !== 8'h01) begin n_fail++; $display("FAIL run_press_wraddr: got %h want 01", wrAddr); end
    sb.push_back('{addr: 8'h01, data: 4'h1});
    while (sb.size() > 0) begin
      e = sb.pop_front(); readAddr = e.addr; #1;
      n_checks++; if (readData !== e.data) begin n_fail++; $display("FAIL coin_read[%h]: got %h want %h", e.addr, readData, e.data); end
    end
  endtask

  task automatic test_reset_mid_load();
    enter_load();
    for (int i = 0; i < 16; i++) press(4'(i + 1), 1'b1);
    n_checks++; if (wrAddr !== 8'h10) begin n_fail++; $display("FAIL midrst_pre_wraddr: got %h want 10", wrAddr); end
    sb.delete();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (cpuHold !== 1'b1) begin n_fail++; $display("FAIL midrst_hold: got %b want 1", cpuHold); end
    n_checks++; if (wrAddr !== 8'h00) begin n_fail++; $display("FAIL midrst_wraddr: got %h want 00", wrAddr); end
    n_checks++; if (loaderState !== 2'b00) begin n_fail++; $display("FAIL midrst_state: got %b want 00", loaderState); end
    @(negedge clk);
    reset = 1'b0;
    loadMode = 1'b0;
    repeat (256) @(posedge clk);
    #1;
    n_checks++; if (loaderState !== 2'b10) begin n_fail++; $display("FAIL midrst_run_state: got %b want 10", loaderState); end
    for (int a = 0; a < 256; a++) sb.push_back('{addr: 8'(a), data: 4'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); readAddr = e.addr; #1;
      n_checks++; if (readData !== e.data) begin n_fail++; $display("FAIL midrst_read[%h]: got %h want %h", e.addr, readData, e.data); end
    end
  endtask

  initial begin
    reset       = 1'b1;
    loadMode    = 1'b0;
    writeStrobe = 1'b0;
    dataIn      = 4'h0;
    readAddr    = 8'h00;
    exp_addr    = 8'h00;
    exp_full    = 1'b0;
    test_reset();
    repeat (2) @(posedge clk);
    test_clear_to_run();
    test_load_basic();
    test_hold_strobe();
    test_fill();
    test_coincident();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the CPU's program-memory interface: replaces the fixed program ROM with a 256×4 RAM that the user fills from the board switches, while the CPU keeps reading it as a combinational opcode store. The block clears the RAM after reset, holds the CPU in reset while a program is being entered, and releases it to run once loading ends. It sits between the board inputs and the CPU's fetch path, driving the opcode bus and the CPU reset.

## Interface
Parameters:
- ADDR_WIDTH, 8, program address width; depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 4, opcode width.

Ports:
- clk  in  1  system clock (divided CPU clock).
- reset  in  1  asynchronous, active-high reset.
- loadMode  in  1  level; 1 requests program-entry mode, 0 requests run.
- writeStrobe  in  1  raw push-button, asynchronous to clk, already debounced.
- dataIn  in  DATA_WIDTH  opcode to store (switches[3:0]).
- readAddr  in  ADDR_WIDTH  CPU program counter.
- readData  out  DATA_WIDTH  opcode at readAddr, combinational.
- cpuHold  out  1  registered; 1 holds the CPU in reset (OR into the CPU reset).
- wrAddr  out  ADDR_WIDTH  registered next write address / words loaded.
- memFull  out  1  registered; 1 once the last address has been written.
- loaderState  out  2  registered state: 00 CLEAR, 01 LOAD, 10 RUN.

## Operation
- Reset (async): state CLEAR, wrAddr 0, memFull 0, cpuHold 1, strobe synchroniser flops 0. Memory contents are not reset directly; CLEAR overwrites them.
- CLEAR: writes 0 to mem[wrAddr] every cycle and increments wrAddr. Takes exactly 2^ADDR_WIDTH cycles. On the cycle that writes address 2^ADDR_WIDTH−1, wrAddr wraps to 0. The next state is LOAD if loadMode = 1, else RUN. loadMode and writeStrobe are ignored during CLEAR.
- RUN: cpuHold 0, no writes. If loadMode = 1, the next state is LOAD, with wrAddr ← 0 and memFull ← 0 on the same edge.
- LOAD: cpuHold 1. Each detected strobe edge writes dataIn to mem[wrAddr]:
  - If wrAddr < 2^ADDR_WIDTH−1, wrAddr increments.
  - At the last address, wrAddr holds and memFull ← 1.
  - While memFull = 1, further strobes are ignored. No wrap and no overwrite.
- LOAD with loadMode = 0: the next state is RUN. wrAddr keeps the program length.
- Strobe detection: writeStrobe feeds a 3-flop chain s1→s2→s3. The write pulse is s2 & ~s3, so there is one write per press regardless of hold length.
- Simultaneous events: a write pulse in the same cycle as loadMode falling is performed, then the block goes to RUN. A pulse arriving in RUN or CLEAR is discarded.
- readData = mem[readAddr] in every state. During CLEAR it returns 0 for already-cleared addresses; the CPU is held in reset there anyway.
- cpuHold = 1 in CLEAR and LOAD, and 0 in RUN. It changes on the same edge as loaderState.

## Timing
- Write latency: writeStrobe sampled high at edge k sets s1. s2 sets at k+1. The memory write and wrAddr update occur at edge k+2.
- CLEAR duration: 256 cycles from reset deassertion (default params). loaderState leaves 00 at the 256th rising edge.
- Mode switch: a change of loadMode sampled at edge n takes effect at edge n. loaderState and cpuHold are valid after that edge; the CPU starts fetching from PC 0 in the following cycle.
- Reset asserted mid-LOAD or mid-RUN: outputs take their reset values immediately. The full CLEAR repeats and the loaded program is lost.
- Memory write is synchronous. Read is asynchronous, with zero-cycle latency from readAddr to readData.

## Test plan
- Reset then hold loadMode = 0 → loaderState 00 for 256 cycles, then 10. cpuHold falls at the same edge. readData = 0 for readAddr 0x00, 0x7F and 0xFF.
- loadMode = 1 after CLEAR; press with dataIn 0x3, 0xA, 0x5; then loadMode = 0 → wrAddr = 3, mem[0..2] = 3, A, 5, cpuHold 0.
- Hold writeStrobe high for 20 cycles in LOAD → exactly one write. wrAddr advances at the 3rd edge after the first sampled high.
- Enter LOAD and issue 257 presses with dataIn = index mod 16 → memFull = 1 after press 256, wrAddr = 0xFF, mem[0xFF] = 0xF. Press 257 changes nothing.
- Write pulse coincident with loadMode falling → the word is written, wrAddr increments, and the state is RUN on that edge.
- Assert reset during LOAD at wrAddr = 0x10 → cpuHold 1 and wrAddr 0 immediately. After 256 cycles, all 256 words read 0.
